// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: self-timed multiplexer for a common-anode seven-segment display.
// It owns its own prescaler and scan counter. Each frame works from a coherent
// snapshot of the display inputs, so the image cannot tear mid-frame. On top of
// plain multiplexing it adds leading-zero blanking, per-digit blink and 16-level
// PWM brightness. All outputs are registered: the values computed from the
// state in cycle t appear on the pins in cycle t+1.
module seg_scan_ctrl #(
  parameter int DIGITS        = 8,
  parameter int SCAN_DIV      = 50000,
  parameter int BLINK_FRAMES  = 128,
  parameter int AN_ACTIVE_LOW = 1,
  localparam int SW           = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   hexs,
  input  logic [DIGITS-1:0]     point,
  input  logic [DIGITS-1:0]     les,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lzb,
  input  logic [3:0]            brightness,
  output logic [3:0]            hexo,
  output logic                  p,
  output logic                  le,
  output logic [DIGITS-1:0]     an,
  output logic [SW-1:0]         scan,
  output logic                  frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIGITS-1:0] AN_IDLE = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]       pre;
  logic [SW-1:0]       scan_idx;
  logic [BW-1:0]       blink_cnt;
  logic                blink_phase;
  logic                load_pend;

  logic [4*DIGITS-1:0] snap_hexs;
  logic [DIGITS-1:0]   snap_point;
  logic [DIGITS-1:0]   snap_les;
  logic [DIGITS-1:0]   snap_blink;
  logic                snap_lzb;
  logic [3:0]          snap_bright;

  logic                pre_wrap;
  logic                frame_end;
  logic                zero_run;
  logic [DIGITS-1:0]   lz_blank;
  logic [DIGITS-1:0]   blank_vec;
  logic [DIGITS-1:0]   one_hot;
  logic [3:0]          cur_hex;
  logic                cur_point;
  logic                cur_blank;
  logic                cur_lit;
  logic [DIGITS-1:0]   an_next;

  assign pre_wrap  = (pre == PW'(SCAN_DIV - 1));
  assign frame_end = pre_wrap && (scan_idx == SW'(DIGITS - 1));

  // Prescaler and digit scan counter; scan advances once per slot and wraps at DIGITS-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre      <= '0;
      scan_idx <= '0;
    end else begin
      pre <= pre_wrap ? '0 : pre + PW'(1);
      if (pre_wrap) begin
        scan_idx <= (scan_idx == SW'(DIGITS - 1)) ? '0 : scan_idx + SW'(1);
      end
    end
  end

  // Blink timebase: count frame ends and flip the blink phase every BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  // Input snapshot: taken at each frame end, or on the first cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_hexs   <= '0;
      snap_point  <= '0;
      snap_les    <= '0;
      snap_blink  <= '0;
      snap_lzb    <= 1'b0;
      snap_bright <= '0;
      load_pend   <= 1'b1;
    end else if (frame_end || load_pend) begin
      snap_hexs   <= hexs;
      snap_point  <= point;
      snap_les    <= les;
      snap_blink  <= blink;
      snap_lzb    <= lzb;
      snap_bright <= brightness;
      load_pend   <= 1'b0;
    end
  end

  // Leading-zero mask: walk from the top digit down, blanking while every nibble so far is zero.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (snap_hexs[4*i +: 4] == 4'h0);
      if (i > 0) lz_blank[i] = zero_run && snap_lzb;
    end
  end

  // Per-cycle selection of the active digit's nibble, point, blank state and anode drive.
  always_comb begin
    blank_vec          = snap_les | (blink_phase ? snap_blink : '0) | lz_blank;
    one_hot            = '0;
    one_hot[scan_idx]  = 1'b1;
    cur_hex            = snap_hexs[{scan_idx, 2'b00} +: 4];
    cur_point          = snap_point[scan_idx];
    cur_blank          = blank_vec[scan_idx];
    cur_lit            = (pre[3:0] <= snap_bright);
    an_next            = AN_IDLE;
    if (cur_lit && !cur_blank) begin
      an_next = (AN_ACTIVE_LOW != 0) ? ~one_hot : one_hot;
    end
  end

  // Output register stage; reset drives a blank, all-anodes-off display.
  always_ff @(posedge clk) begin
    if (rst) begin
      hexo       <= 4'h0;
      p          <= 1'b0;
      le         <= 1'b1;
      an         <= AN_IDLE;
      scan       <= '0;
      frame_tick <= 1'b0;
    end else begin
      hexo       <= cur_hex;
      p          <= cur_point;
      le         <= cur_blank;
      an         <= an_next;
      scan       <= scan_idx;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (DIGITS=8, SCAN_DIV=16,
// BLINK_FRAMES=2, active-low anodes). The driver computes the expected output
// of every cycle from a cycle-count model and queues it; the monitor pops and
// compares after every clock edge.
module tb_seg_scan_ctrl;

  localparam int DIGITS       = 8;
  localparam int SCAN_DIV     = 16;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hexs;
  logic [7:0]  point, les, blink;
  logic        lzb;
  logic [3:0]  brightness;
  logic [3:0]  hexo;
  logic        p, le;
  logic [7:0]  an;
  logic [2:0]  scan;
  logic        frame_tick;

  typedef struct packed {
    logic [3:0] hexo;
    logic       p;
    logic       le;
    logic [7:0] an;
    logic [2:0] scan;
    logic       ft;
  } exp_t;

  typedef struct packed {
    logic [31:0] hexs;
    logic [7:0]  point;
    logic [7:0]  les;
    logic [7:0]  blink;
    logic        lzb;
    logic [3:0]  bright;
  } snap_t;

  exp_t  exp_q[$];
  snap_t model_snap;
  int    c = 0;
  int    total = 0;
  int    bad = 0;

  logic [31:0] cur_hexs;
  logic [7:0]  cur_point, cur_les, cur_blink;
  logic        cur_lzb;
  logic [3:0]  cur_bright;

  seg_scan_ctrl #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .hexs(hexs), .point(point), .les(les), .blink(blink),
    .lzb(lzb), .brightness(brightness), .hexo(hexo), .p(p), .le(le), .an(an),
    .scan(scan), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s at t=%0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue the output expected after the next edge.
  task automatic applyStimulus(input logic r);
    exp_t        e;
    logic [31:0] tail;
    logic [7:0]  oh;
    int          pre, d, f, phase;
    logic        blank;
    @(negedge clk);
    rst        = r;
    hexs       = cur_hexs;
    point      = cur_point;
    les        = cur_les;
    blink      = cur_blink;
    lzb        = cur_lzb;
    brightness = cur_bright;
    if (r) begin
      e = '{hexo: 4'h0, p: 1'b0, le: 1'b1, an: 8'hFF, scan: 3'd0, ft: 1'b0};
      c = 0;
      model_snap = '0;
    end else begin
      pre   = c % SCAN_DIV;
      d     = (c / SCAN_DIV) % DIGITS;
      f     = c / FRAME;
      phase = (f / BLINK_FRAMES) % 2;
      tail  = model_snap.hexs >> (4 * d);
      blank = model_snap.les[d] || (phase == 1 && model_snap.blink[d]) ||
              (model_snap.lzb && d > 0 && tail == 32'h0);
      oh     = 8'h01 << d;
      e.hexo = tail[3:0];
      e.p    = model_snap.point[d];
      e.le   = blank;
      e.an   = (!blank && pre <= int'(model_snap.bright)) ? ~oh : 8'hFF;
      e.scan = 3'(d);
      e.ft   = (c % FRAME == FRAME - 1);
      if (c == 0 || c % FRAME == FRAME - 1) begin
        model_snap = '{hexs: cur_hexs, point: cur_point, les: cur_les, blink: cur_blink,
                       lzb: cur_lzb, bright: cur_bright};
      end
      c++;
    end
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0);
  endtask

  task automatic randomizeInputs();
    cur_hexs   = $urandom >> $urandom_range(0, 31);
    cur_point  = 8'($urandom);
    cur_les    = 8'($urandom) & 8'($urandom);
    cur_blink  = 8'($urandom);
    cur_lzb    = 1'($urandom);
    cur_bright = 4'($urandom);
  endtask

  // Monitor: after each edge, compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("hexo", hexo, e.hexo);
        checkOutput("p", p, e.p);
        checkOutput("le", le, e.le);
        checkOutput("an", an, e.an);
        checkOutput("scan", scan, e.scan);
        checkOutput("frame_tick", frame_tick, e.ft);
      end
    end
  end

  // Global time limit so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "[TB] timeout");
  end

  // Stimulus sequence: reset, scan, snapshot coherence, LZ blanking, blink, PWM, random, mid-frame reset.
  initial begin
    int waited;
    rst = 1'b1; hexs = '0; point = '0; les = '0; blink = '0; lzb = 1'b0; brightness = '0;
    cur_hexs = 32'h76543210; cur_point = 8'h00; cur_les = 8'h00; cur_blink = 8'h00;
    cur_lzb = 1'b0; cur_bright = 4'd15;
    model_snap = '0;

    repeat (3) applyStimulus(1'b1);
    run(48);
    cur_hexs = 32'hFFFFFFFF;
    run(80 + FRAME);

    cur_hexs = 32'h00000A05; cur_lzb = 1'b1;
    run(2 * FRAME);

    cur_hexs = 32'h76543210; cur_lzb = 1'b0; cur_blink = 8'h01;
    run(6 * FRAME);
    cur_bright = 4'd3;
    run(FRAME);

    for (int i = 0; i < 12 * FRAME; i++) begin
      if ($urandom_range(0, 39) == 0) randomizeInputs();
      applyStimulus(1'b0);
    end

    while (c % FRAME != 5 * SCAN_DIV) applyStimulus(1'b0);
    randomizeInputs();
    repeat (2) applyStimulus(1'b1);
    randomizeInputs();
    cur_blink = 8'hFF;
    run(3 * FRAME);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
